// File: rtl/comparator_seq_nbit.sv
// Multi-cycle MSB-first magnitude comparator: STEP bits per clock, unsigned or
// two's-complement, early exit at the first differing chunk, start/busy/done handshake.
`timescale 1ns/1ps
module comparator_seq_nbit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic [STEP-1:0]  a_chunk;
  logic [STEP-1:0]  b_chunk;
  logic [WIDTH-1:0] op_a_sh;
  logic [WIDTH-1:0] op_b_sh;

  // Operands are shifted left each cycle so the current chunk is always the top STEP bits.
  assign a_chunk = op_a_q[WIDTH-1 -: STEP];
  assign b_chunk = op_b_q[WIDTH-1 -: STEP];

  if (N > 1) begin : g_shift
    assign op_a_sh = {op_a_q[WIDTH-STEP-1:0], {STEP{1'b0}}};
    assign op_b_sh = {op_b_q[WIDTH-STEP-1:0], {STEP{1'b0}}};
  end else begin : g_no_shift
    assign op_a_sh = '0;
    assign op_b_sh = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // Flipping both MSBs maps two's-complement order onto unsigned order.
            op_a_q  <= a_i ^ (signed_mode_i ? MSB_MASK : '0);
            op_b_q  <= b_i ^ (signed_mode_i ? MSB_MASK : '0);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (a_chunk != b_chunk) begin
            gt_q    <= (a_chunk > b_chunk);
            lt_q    <= (a_chunk < b_chunk);
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (idx_q == IDX_LAST) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
            op_a_q <= op_a_sh;
            op_b_q <= op_b_sh;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign gt_o   = gt_q;
  assign lt_o   = lt_q;
  assign eq_o   = eq_q;

endmodule

// File: tb/tb_comparator_seq_nbit.sv
// Scoreboard bench for comparator_seq_nbit: three parameterisations (16/4, 16/1, 8/8)
// checked against an integer reference compare and first-differing-chunk latency.
`timescale 1ns/1ps
module tb_comparator_seq_nbit;

  typedef struct {
    int         dut;
    logic [2:0] res;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        sm;
  logic [15:0] a_v;
  logic [15:0] b_v;
  logic [2:0]  busy_w, done_w, gt_w, lt_w, eq_w;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [2:0]  held[3];
  int          last_done;
  logic [2:0]  last_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_seq_nbit #(.WIDTH(16), .STEP(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .signed_mode_i(sm),
    .a_i(a_v), .b_i(b_v), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .gt_o(gt_w[0]), .lt_o(lt_w[0]), .eq_o(eq_w[0]));

  comparator_seq_nbit #(.WIDTH(16), .STEP(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .signed_mode_i(sm),
    .a_i(a_v), .b_i(b_v), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .gt_o(gt_w[1]), .lt_o(lt_w[1]), .eq_o(eq_w[1]));

  comparator_seq_nbit #(.WIDTH(8), .STEP(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .signed_mode_i(sm),
    .a_i(a_v[7:0]), .b_i(b_v[7:0]), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .gt_o(gt_w[2]), .lt_o(lt_w[2]), .eq_o(eq_w[2]));

  function automatic int width_of(input int d);
    return (d == 2) ? 8 : 16;
  endfunction

  function automatic int step_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  // Reference: integer compare for the result, first nonzero chunk of a^b for latency.
  function automatic void model(input int d, input logic [15:0] a, input logic [15:0] b,
                                input logic s, output logic [2:0] res, output int lat);
    int w  = width_of(d);
    int st = step_of(d);
    int n  = w / st;
    int mask = (1 << w) - 1;
    int av = int'(a) & mask;
    int bv = int'(b) & mask;
    int x  = av ^ bv;
    if (s && av >= (1 << (w - 1))) av -= (1 << w);
    if (s && bv >= (1 << (w - 1))) bv -= (1 << w);
    res = (av > bv) ? 3'b100 : ((av < bv) ? 3'b010 : 3'b001);
    lat = n;
    for (int j = n - 1; j >= 0; j--)
      if (((x >> (w - (j + 1) * st)) & ((1 << st) - 1)) != 0) lat = j + 1;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Waits (bounded) for the DUT to be idle, pulses start, pushes the expectation.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic s, output int acc);
    exp_t       e;
    logic [2:0] res;
    int         lat;
    int         n = 0;
    while (busy_w[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[d]) begin
      chk("issue_idle_timeout", int'(busy_w[d]), 0);
      acc = -1;
      return;
    end
    a_v = a;
    b_v = b;
    sm  = s;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    acc = cyc;
    model(d, a, b, s, res, lat);
    e.dut      = d;
    e.res      = res;
    e.done_cyc = cyc + lat;
    q.push_back(e);
    last_done = e.done_cyc;
    last_res  = res;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (done_w[d]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: dut%0d done=1 at cycle %0d, expected no pending compare", d, cyc);
          end else begin
            e = q.pop_front();
            chk("done_from_dut", d, e.dut);
            chk("result_gt_lt_eq", int'({gt_w[d], lt_w[d], eq_w[d]}), int'(e.res));
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_at_done", int'(busy_w[d]), 0);
            held[d] = e.res;
          end
        end else begin
          chk("result_held", int'({gt_w[d], lt_w[d], eq_w[d]}), int'(held[d]));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int          acc;
    int          acc2;
    int          saved_done;
    logic [2:0]  saved_res;
    logic [15:0] ra, rb;
    int          r;
    for (int d = 0; d < 3; d++) held[d] = 3'b000;
    rst_n   = 1'b0;
    start_v = '1;
    sm      = 1'($urandom);
    a_v     = 16'($urandom);
    b_v     = 16'($urandom);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", int'(busy_w[d]), 0);
      chk("reset_done", int'(done_w[d]), 0);
      chk("reset_result", int'({gt_w[d], lt_w[d], eq_w[d]}), 0);
    end
    start_v = '0;
    rst_n   = 1'b1;

    // Unsigned early exit at chunk 2; a second start while busy must be ignored.
    issue(0, 16'h12F4, 16'h1234, 1'b0, acc);
    chk("busy_e0", int'(busy_w[0]), 1);
    a_v = 16'hFFFF;
    b_v = 16'h0000;
    sm  = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("busy_e1", int'(busy_w[0]), 1);
    @(negedge clk);
    chk("busy_e2", int'(busy_w[0]), 1);
    @(negedge clk);
    chk("done_e3", int'(done_w[0]), 1);
    chk("gt_e3", int'(gt_w[0]), 1);
    chk("busy_e3", int'(busy_w[0]), 0);
    @(negedge clk);
    chk("ignored_start_idle", int'(busy_w[0]), 0);

    issue(0, 16'h1234, 16'h1234, 1'b0, acc);
    issue(0, 16'h0000, 16'h0001, 1'b0, acc);
    issue(0, 16'h8000, 16'h0001, 1'b1, acc);
    issue(0, 16'h8000, 16'h0001, 1'b0, acc);
    issue(0, 16'hFFFF, 16'hFFFE, 1'b1, acc);
    drain();

    // Back-to-back: second start lands in the done cycle of the first.
    issue(0, 16'h8000, 16'h0001, 1'b1, acc);
    saved_done = last_done;
    saved_res  = last_res;
    issue(0, 16'h0005, 16'h0003, 1'b0, acc2);
    chk("b2b_accept_cycle", acc2, saved_done + 1);
    chk("b2b_busy", int'(busy_w[0]), 1);
    chk("b2b_prev_held", int'({gt_w[0], lt_w[0], eq_w[0]}), int'(saved_res));

    // Abort mid-run: outputs clear asynchronously and no done follows.
    issue(0, 16'h0000, 16'h0001, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_done", int'(done_w[0]), 0);
    chk("abort_result", int'({gt_w[0], lt_w[0], eq_w[0]}), 0);
    q.delete();
    held[0] = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Random sweep over all three parameterisations.
    for (int d = 0; d < 3; d++) begin
      repeat (40) begin
        ra = 16'($urandom);
        r  = int'($urandom_range(0, 3));
        case (r)
          0:       rb = ra;
          1:       rb = ra ^ (16'(1) << $urandom_range(0, 15));
          2:       rb = 16'($urandom);
          default: rb = ra ^ (16'(1) << $urandom_range(0, 3));
        endcase
        issue(d, ra, rb, 1'($urandom), acc);
      end
      drain();
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
